rx_pattern_detector_mp: RTL and testbench
=========================================

Name: rx_pattern_detector_mp

Overview:
- Next-generation streaming packet-type/symbol detector for the network clock domain.
- Generalises the fixed 4-pattern detector to NUM_PAT programmable patterns, each with a per-pattern enable.
- Produces one match record per packet into an internal output queue with ready/valid backpressure toward the CDC FIFO writer.
- Keeps saturating per-pattern hit counters plus drop and abort counters for host monitoring.

Parameters:
NUM_PAT, 8, number of programmable patterns (1..16)
PTYPE_OFFSET, 16, byte offset of 32-bit packet type from packet start (multiple of 4, 0..56)
SYM_OFFSET, 24, byte offset of 64-bit symbol from packet start (multiple of 8, 0..56)
OUT_DEPTH, 4, output record queue depth (power of 2, >=2)
CNT_W, 16, width of all counters
IDX_W, $clog2(NUM_PAT) (min 1), derived width of pattern index fields

Ports:
clk_net  in  1  network clock
rst_n  in  1  asynchronous active-low reset
valid  in  1  input beat valid
sop  in  1  first beat of packet
eop  in  1  last beat of packet
length  in  3  valid bytes in eop beat; 0 means 8
data  in  64  beat data; packet byte 0 of each beat on [63:56]
pat_type  in  32*NUM_PAT  packet-type pattern i at [32i+31:32i]
pat_symbol  in  64*NUM_PAT  symbol pattern i at [64i+63:64i]
pat_en  in  NUM_PAT  per-pattern enable
out_valid  out  1  record available
out_ready  in  1  consumer accepts record
out_match  out  NUM_PAT  bitmap of matching enabled patterns
out_hit  out  1  |out_match
out_idx  out  IDX_W  lowest matching index; 0 when no hit
out_short  out  1  packet ended before both fields were captured
cnt_sel  in  IDX_W  hit counter select
cnt_hits  out  CNT_W  hit counter of pattern cnt_sel (combinational read)
cnt_drops  out  CNT_W  records lost to full queue
cnt_aborts  out  CNT_W  packets restarted by sop before eop
cnt_clear  in  1  synchronous clear of all counters

Behaviour:
- Reset: FSM=IDLE, queue empty, all counters 0, captured fields and flags 0; out_valid=0, out_match=0, out_hit=0, out_idx=0, out_short=0.
- FSM states:
  - IDLE: waits for valid&&sop.
  - IN_PKT: beats accepted until eop.
  - valid without sop in IDLE is ignored.
  - valid&&sop&&eop (single-beat packet) is a complete packet.
- Beat counter: reset to 0 on a sop beat, +1 per accepted beat, saturates at 7.
- Capture:
  - Packet type = bytes PTYPE_OFFSET..+3, taken from beat PTYPE_OFFSET/8.
  - Symbol = beat SYM_OFFSET/8.
  - Each field has a captured flag, cleared on sop.
  - A byte counts as captured only if it lies within the valid bytes of that beat (eop length honoured).
- Match: at the eop beat (cycle T), using captured fields including the eop beat itself, match[i] = pat_en[i] && type==pat_type[i] && sym==pat_symbol[i]; pat_* and pat_en are sampled at T.
- Short packet: if either flag is clear at eop, match=0 and short=1.
- Latency: the record is registered and written to the queue at T+1; out_valid is high at T+2 at the earliest; the FSM is back in IDLE at T+1.
- Back-to-back packets (sop at T+1) are fully supported; no bubbles are required.
- sop while IN_PKT: the current packet is discarded without a record, cnt_aborts+1, and a new packet starts with this beat.
- Queue: first-word fall-through. The record pops on out_valid&&out_ready. If the queue is full at write time, the record is dropped and cnt_drops+1. A simultaneous pop and push while full is accepted with no drop.
- Counters: each +1 per event and saturates at 2^CNT_W-1. hits[i] increments when the record with match[i] is written. cnt_clear has priority over a same-cycle increment.
- Reset mid-packet: the packet is discarded and the queue is flushed.

Test Plan:
- NUM_PAT=8, pat_type3=32'hAABBCCDD, pat_symbol3=64'h1122334455667788, pat_en=8'hFF; 5-beat packet containing those fields -> out_valid at eop+2, out_match=8'h08, out_idx=3, out_hit=1, out_short=0, cnt_hits[3]=1.
- Patterns 2 and 5 identical, pat_en=8'b0010_0000; matching packet -> out_match=8'h20, out_idx=5; then pat_en=0 on the same packet -> out_hit=0, out_idx=0.
- 3-beat packet (eop at beat 2, length=4) -> out_short=1, out_match=0; eop at beat 3 with length=3 -> symbol not captured, out_short=1.
- out_ready=0, 6 matching packets, OUT_DEPTH=4 -> 4 records held, cnt_drops=2; raising out_ready drains the 4 records in order, one per cycle.
- sop at beat 2 of an open packet, then a full matching packet -> cnt_aborts=1, exactly one record produced; single-beat sop&&eop packet -> one record with out_short=1.
- Hit counter pre-driven to 16'hFFFF -> stays FFFF on the next hit; cnt_clear in the same cycle as a hit -> counter reads 0.

Source files
------------

// File: rtl/rx_pattern_detector_mp_if.sv
// Streaming beat input and match-record output bundle for rx_pattern_detector_mp.
interface rx_pattern_detector_mp_if #(
  parameter int NUM_PAT = 8,
  parameter int IDX_W   = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) ();
  logic               valid;
  logic               sop;
  logic               eop;
  logic [2:0]         length;
  logic [63:0]        data;
  logic               out_valid;
  logic               out_ready;
  logic [NUM_PAT-1:0] out_match;
  logic               out_hit;
  logic [IDX_W-1:0]   out_idx;
  logic               out_short;

  modport master (
    output valid, sop, eop, length, data, out_ready,
    input  out_valid, out_match, out_hit, out_idx, out_short
  );

  modport slave (
    input  valid, sop, eop, length, data, out_ready,
    output out_valid, out_match, out_hit, out_idx, out_short
  );
endinterface

// File: rtl/rx_pattern_detector_mp.sv
// Streaming packet-type/symbol detector: NUM_PAT programmable patterns, one match
// record per packet into a FWFT queue, saturating hit/drop/abort counters.
module rx_pattern_detector_mp #(
  parameter int NUM_PAT      = 8,
  parameter int PTYPE_OFFSET = 16,
  parameter int SYM_OFFSET   = 24,
  parameter int OUT_DEPTH    = 4,
  parameter int CNT_W        = 16,
  parameter int IDX_W        = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
  input  logic                   clk_net,
  input  logic                   rst_n,
  rx_pattern_detector_mp_if.slave bus,
  input  logic [32*NUM_PAT-1:0]  pat_type,
  input  logic [64*NUM_PAT-1:0]  pat_symbol,
  input  logic [NUM_PAT-1:0]     pat_en,
  input  logic [IDX_W-1:0]       cnt_sel,
  output logic [CNT_W-1:0]       cnt_hits,
  output logic [CNT_W-1:0]       cnt_drops,
  output logic [CNT_W-1:0]       cnt_aborts,
  input  logic                   cnt_clear
);

  localparam int         PT_BYTE  = PTYPE_OFFSET % 8;
  localparam logic [2:0] PT_BEAT  = 3'(PTYPE_OFFSET / 8);
  localparam logic [2:0] SYM_BEAT = 3'(SYM_OFFSET / 8);
  localparam logic [3:0] PT_NEED  = 4'(PT_BYTE + 4);
  localparam int         PTR_W    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t             state_q, state_d;
  logic [2:0]         beat_q, beat_d, cur_beat;
  logic [31:0]        pt_q, pt_eff;
  logic [63:0]        sym_q, sym_eff;
  logic               pt_flag_q, sym_flag_q;
  logic               pt_flag_base, sym_flag_base, pt_flag_eff, sym_flag_eff;
  logic               pt_cap, sym_cap;
  logic [3:0]         nbytes;
  logic               beat_acc, abort;
  logic               rec_valid_d, rec_valid_q;
  logic [NUM_PAT-1:0] rec_match_d, rec_match_q;
  logic               rec_short_d, rec_short_q;

  logic [NUM_PAT-1:0] qm_q [OUT_DEPTH];
  logic               qs_q [OUT_DEPTH];
  logic [PTR_W-1:0]   wr_q, rd_q;
  logic [PTR_W:0]     cnt_q;
  logic               full, pop, push, drop;

  logic [CNT_W-1:0]   hits_q [NUM_PAT];
  logic [CNT_W-1:0]   hits_rd [2**IDX_W];
  logic [CNT_W-1:0]   drops_q, aborts_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // State register
  always_ff @(posedge clk_net or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (beat_acc) state_d = bus.eop ? IDLE : IN_PKT;
  end

  // Output / datapath control: a sop beat is accepted in either state and always
  // restarts capture, so flags are viewed as cleared while it is on the bus.
  always_comb begin
    beat_acc      = bus.valid && (bus.sop || (state_q == IN_PKT));
    abort         = bus.valid && bus.sop && (state_q == IN_PKT);
    cur_beat      = bus.sop ? 3'd0 : beat_q;
    beat_d        = beat_q;
    if (beat_acc) beat_d = (cur_beat == 3'd7) ? 3'd7 : cur_beat + 3'd1;
    nbytes        = (!bus.eop || (bus.length == 3'd0)) ? 4'd8 : {1'b0, bus.length};
    pt_flag_base  = pt_flag_q && !bus.sop;
    sym_flag_base = sym_flag_q && !bus.sop;
    pt_cap        = beat_acc && !pt_flag_base && (cur_beat == PT_BEAT) && (nbytes >= PT_NEED);
    sym_cap       = beat_acc && !sym_flag_base && (cur_beat == SYM_BEAT) && (nbytes == 4'd8);
    pt_eff        = pt_cap ? bus.data[63-8*PT_BYTE -: 32] : pt_q;
    sym_eff       = sym_cap ? bus.data : sym_q;
    pt_flag_eff   = pt_flag_base || pt_cap;
    sym_flag_eff  = sym_flag_base || sym_cap;
    rec_valid_d   = beat_acc && bus.eop;
    rec_short_d   = !(pt_flag_eff && sym_flag_eff);
    rec_match_d   = '0;
    for (int unsigned i = 0; i < NUM_PAT; i++) begin
      rec_match_d[i] = pat_en[i] && !rec_short_d &&
                       (pt_eff == pat_type[32*i +: 32]) &&
                       (sym_eff == pat_symbol[64*i +: 64]);
    end
  end

  always_ff @(posedge clk_net or negedge rst_n) begin
    if (!rst_n) begin
      beat_q      <= '0;
      pt_q        <= '0;
      sym_q       <= '0;
      pt_flag_q   <= 1'b0;
      sym_flag_q  <= 1'b0;
      rec_valid_q <= 1'b0;
      rec_match_q <= '0;
      rec_short_q <= 1'b0;
    end else begin
      beat_q      <= beat_d;
      if (pt_cap)  pt_q  <= pt_eff;
      if (sym_cap) sym_q <= sym_eff;
      if (beat_acc) begin
        pt_flag_q  <= pt_flag_eff;
        sym_flag_q <= sym_flag_eff;
      end
      rec_valid_q <= rec_valid_d;
      rec_match_q <= rec_match_d;
      rec_short_q <= rec_short_d;
    end
  end

  // Record queue: a pop frees the slot in the same cycle, so push-while-full with pop is kept.
  always_comb begin
    full = (cnt_q == (PTR_W+1)'(OUT_DEPTH));
    pop  = (cnt_q != '0) && bus.out_ready;
    push = rec_valid_q && (!full || pop);
    drop = rec_valid_q && full && !pop;
  end

  always_ff @(posedge clk_net or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
        qm_q[i] <= '0;
        qs_q[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        qm_q[wr_q] <= rec_match_q;
        qs_q[wr_q] <= rec_short_q;
        wr_q       <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_comb begin
    bus.out_valid = (cnt_q != '0);
    bus.out_match = bus.out_valid ? qm_q[rd_q] : '0;
    bus.out_short = bus.out_valid && qs_q[rd_q];
    bus.out_hit   = |bus.out_match;
    bus.out_idx   = '0;
    for (int unsigned i = NUM_PAT; i > 0; i--) begin
      if (bus.out_match[i-1]) bus.out_idx = IDX_W'(i-1);
    end
  end

  always_ff @(posedge clk_net or negedge rst_n) begin
    if (!rst_n) begin
      drops_q  <= '0;
      aborts_q <= '0;
      for (int unsigned i = 0; i < NUM_PAT; i++) hits_q[i] <= '0;
    end else if (cnt_clear) begin
      drops_q  <= '0;
      aborts_q <= '0;
      for (int unsigned i = 0; i < NUM_PAT; i++) hits_q[i] <= '0;
    end else begin
      if (drop)  drops_q  <= sat_inc(drops_q);
      if (abort) aborts_q <= sat_inc(aborts_q);
      for (int unsigned i = 0; i < NUM_PAT; i++) begin
        if (push && rec_match_q[i]) hits_q[i] <= sat_inc(hits_q[i]);
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 2**IDX_W; i++) hits_rd[i] = '0;
    for (int unsigned i = 0; i < NUM_PAT; i++)  hits_rd[i] = hits_q[i];
    cnt_hits   = hits_rd[cnt_sel];
    cnt_drops  = drops_q;
    cnt_aborts = aborts_q;
  end

endmodule

// File: tb/tb_rx_pattern_detector_mp.sv
// Directed bench for rx_pattern_detector_mp; a second instance with 4-bit counters
// exercises counter saturation in a short run.
module tb_rx_pattern_detector_mp;

  logic         clk_net = 1'b0;
  logic         rst_n   = 1'b1;
  logic [255:0] pat_type;
  logic [511:0] pat_symbol;
  logic [7:0]   pat_en;
  logic [2:0]   cnt_sel;
  logic         cnt_clear;
  logic [15:0]  cnt_hits, cnt_drops, cnt_aborts;
  logic [3:0]   cnt_hits2, cnt_drops2, cnt_aborts2;
  logic [31:0]  pt [8];
  logic [63:0]  ps [8];
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 clk_net = ~clk_net;

  rx_pattern_detector_mp_if #(.NUM_PAT(8)) bus ();
  rx_pattern_detector_mp_if #(.NUM_PAT(8)) bus2 ();

  assign bus2.valid     = bus.valid;
  assign bus2.sop       = bus.sop;
  assign bus2.eop       = bus.eop;
  assign bus2.length    = bus.length;
  assign bus2.data      = bus.data;
  assign bus2.out_ready = 1'b1;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pat_type[32*i +: 32]   = pt[i];
      pat_symbol[64*i +: 64] = ps[i];
    end
  end

  rx_pattern_detector_mp #(.NUM_PAT(8), .CNT_W(16)) dut (
    .clk_net(clk_net), .rst_n(rst_n), .bus(bus),
    .pat_type(pat_type), .pat_symbol(pat_symbol), .pat_en(pat_en),
    .cnt_sel(cnt_sel), .cnt_hits(cnt_hits), .cnt_drops(cnt_drops),
    .cnt_aborts(cnt_aborts), .cnt_clear(cnt_clear)
  );

  rx_pattern_detector_mp #(.NUM_PAT(8), .CNT_W(4)) dut_small (
    .clk_net(clk_net), .rst_n(rst_n), .bus(bus2),
    .pat_type(pat_type), .pat_symbol(pat_symbol), .pat_en(pat_en),
    .cnt_sel(3'd3), .cnt_hits(cnt_hits2), .cnt_drops(cnt_drops2),
    .cnt_aborts(cnt_aborts2), .cnt_clear(cnt_clear)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_net);
    #1;
  endtask

  task automatic idle();
    bus.valid = 1'b0;
    bus.sop   = 1'b0;
    bus.eop   = 1'b0;
  endtask

  task automatic beat(input logic s, input logic e, input logic [2:0] len, input logic [63:0] d);
    bus.valid  = 1'b1;
    bus.sop    = s;
    bus.eop    = e;
    bus.length = len;
    bus.data   = d;
    tick();
  endtask

  // Beat 2 carries the type in bytes 0..3, beat 3 carries the symbol.
  task automatic send_pkt(input int n, input logic [31:0] t, input logic [63:0] s,
                          input logic [2:0] len, input bit b2b);
    logic [63:0] d;
    for (int b = 0; b < n; b++) begin
      d = (b == 2) ? {t, 32'h5A5A_5A5A} : (b == 3) ? s : (64'hF0F0_0000_0000_0000 | 64'(b));
      beat(b == 0, b == n - 1, (b == n - 1) ? len : 3'd0, d);
    end
    if (!b2b) idle();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      pt[i] = 32'h1000_0000 + 32'(i);
      ps[i] = 64'h2000_0000_0000_0000 + 64'(i);
    end
    pt[3] = 32'hAABB_CCDD;
    ps[3] = 64'h1122_3344_5566_7788;
    pat_en        = 8'hFF;
    cnt_sel       = 3'd3;
    cnt_clear     = 1'b0;
    bus.out_ready = 1'b1;
    bus.length    = 3'd0;
    bus.data      = '0;
    idle();

    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_match", 64'(bus.out_match), 64'd0);
    chk("rst_out_hit",   64'(bus.out_hit),   64'd0);
    chk("rst_out_idx",   64'(bus.out_idx),   64'd0);
    chk("rst_out_short", 64'(bus.out_short), 64'd0);
    chk("rst_cnt_hits",  64'(cnt_hits),      64'd0);
    chk("rst_cnt_drops", 64'(cnt_drops),     64'd0);
    chk("rst_cnt_abort", 64'(cnt_aborts),    64'd0);
    rst_n = 1'b1;
    tick();

    // Basic match: record visible two cycles after the eop beat.
    send_pkt(5, pt[3], ps[3], 3'd0, 1'b0);
    chk("t1_valid_T1", 64'(bus.out_valid), 64'd0);
    tick();
    chk("t1_valid_T2", 64'(bus.out_valid), 64'd1);
    chk("t1_match",    64'(bus.out_match), 64'h08);
    chk("t1_idx",      64'(bus.out_idx),   64'd3);
    chk("t1_hit",      64'(bus.out_hit),   64'd1);
    chk("t1_short",    64'(bus.out_short), 64'd0);
    chk("t1_hits3",    64'(cnt_hits),      64'd1);
    tick();
    chk("t1_popped",   64'(bus.out_valid), 64'd0);

    // Duplicate patterns 2 and 5, only 5 enabled; then nothing enabled.
    pt[2] = 32'hCAFE_F00D; ps[2] = 64'h0123_4567_89AB_CDEF;
    pt[5] = 32'hCAFE_F00D; ps[5] = 64'h0123_4567_89AB_CDEF;
    pat_en = 8'b0010_0000;
    send_pkt(4, 32'hCAFE_F00D, 64'h0123_4567_89AB_CDEF, 3'd0, 1'b0);
    tick();
    chk("t2_match", 64'(bus.out_match), 64'h20);
    chk("t2_idx",   64'(bus.out_idx),   64'd5);
    tick();
    pat_en = 8'h00;
    send_pkt(4, 32'hCAFE_F00D, 64'h0123_4567_89AB_CDEF, 3'd0, 1'b0);
    tick();
    chk("t2_off_valid", 64'(bus.out_valid), 64'd1);
    chk("t2_off_hit",   64'(bus.out_hit),   64'd0);
    chk("t2_off_idx",   64'(bus.out_idx),   64'd0);
    tick();
    pat_en = 8'hFF;

    // Short packets and eop length handling.
    send_pkt(3, pt[3], ps[3], 3'd4, 1'b0);
    tick();
    chk("t3a_short", 64'(bus.out_short), 64'd1);
    chk("t3a_match", 64'(bus.out_match), 64'd0);
    tick();
    send_pkt(4, pt[3], ps[3], 3'd3, 1'b0);
    tick();
    chk("t3b_short", 64'(bus.out_short), 64'd1);
    chk("t3b_match", 64'(bus.out_match), 64'd0);
    tick();
    send_pkt(4, pt[3], ps[3], 3'd0, 1'b0);
    tick();
    chk("t3c_short", 64'(bus.out_short), 64'd0);
    chk("t3c_match", 64'(bus.out_match), 64'h08);
    tick();

    // Backpressure: six back-to-back packets into a 4-deep queue.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) send_pkt(4, pt[k], ps[k], 3'd0, k != 5);
    tick();
    chk("t4_drops", 64'(cnt_drops),     64'd2);
    chk("t4_valid", 64'(bus.out_valid), 64'd1);
    cnt_sel = 3'd4;
    #1;
    chk("t4_hits4_dropped", 64'(cnt_hits), 64'd0);
    cnt_sel = 3'd3;
    bus.out_ready = 1'b1;
    #1;
    chk("t4_drain0", 64'(bus.out_idx), 64'd0);
    tick();
    chk("t4_drain1", 64'(bus.out_idx), 64'd1);
    tick();
    chk("t4_drain2", 64'(bus.out_idx), 64'd2);
    tick();
    chk("t4_drain3", 64'(bus.out_idx), 64'd3);
    tick();
    chk("t4_empty",  64'(bus.out_valid), 64'd0);

    // Abort by sop inside an open packet.
    beat(1'b1, 1'b0, 3'd0, 64'hDEAD_BEEF_0000_0000);
    beat(1'b0, 1'b0, 3'd0, 64'hDEAD_BEEF_0000_0001);
    send_pkt(4, pt[3], ps[3], 3'd0, 1'b0);
    chk("t5_aborts", 64'(cnt_aborts), 64'd1);
    tick();
    chk("t5_rec_valid", 64'(bus.out_valid), 64'd1);
    chk("t5_rec_idx",   64'(bus.out_idx),   64'd3);
    tick();
    chk("t5_one_rec",   64'(bus.out_valid), 64'd0);

    // Single-beat packet and a stray beat outside any packet.
    send_pkt(1, pt[3], ps[3], 3'd0, 1'b0);
    tick();
    chk("t6_single_valid", 64'(bus.out_valid), 64'd1);
    chk("t6_single_short", 64'(bus.out_short), 64'd1);
    chk("t6_single_match", 64'(bus.out_match), 64'd0);
    tick();
    beat(1'b0, 1'b1, 3'd0, 64'h0);
    idle();
    tick();
    tick();
    chk("t6_stray_ignored", 64'(bus.out_valid), 64'd0);

    // Saturation on the 4-bit instance, then clear racing a hit.
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    chk("t7_cleared", 64'(cnt_hits2), 64'd0);
    for (int k = 0; k < 15; k++) send_pkt(4, pt[3], ps[3], 3'd0, 1'b0);
    tick();
    chk("t7_hits_15", 64'(cnt_hits2), 64'hF);
    send_pkt(4, pt[3], ps[3], 3'd0, 1'b0);
    tick();
    chk("t7_hits_sat",  64'(cnt_hits2), 64'hF);
    chk("t7_main_hits", 64'(cnt_hits),  64'h10);
    send_pkt(4, pt[3], ps[3], 3'd0, 1'b0);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    chk("t7_clr_wins_main",  64'(cnt_hits),  64'd0);
    chk("t7_clr_wins_small", 64'(cnt_hits2), 64'd0);
    tick();
    chk("t7_clr_stays", 64'(cnt_hits), 64'd0);

    // Reset flushes a held record.
    bus.out_ready = 1'b0;
    send_pkt(4, pt[3], ps[3], 3'd0, 1'b0);
    tick();
    chk("t8_held", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t8_flushed", 64'(bus.out_valid), 64'd0);
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
